// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - MMIO register offsets (low address byte inside the MMIO window)
//   - STATUS register bit positions
//   - default MMIO window selector (addr[31:16])
//   - status_word(): packs FIFO state into the STATUS register layout
package dmem_pkg;

    typedef enum logic [7:0] {
        OFF_CYCLE  = 8'h00,
        OFF_GPIO   = 8'h04,
        OFF_TXDATA = 8'h08,
        OFF_STATUS = 8'h0C
    } mmio_off_e;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    localparam logic [15:0] MMIO_HI_DEFAULT = 16'hFFFF;

    // STATUS layout: empty/full/overflow flags in the low bits, count in [15:8].
    function automatic logic [31:0] status_word(input logic       empty,
                                                input logic       full,
                                                input logic       ovf,
                                                input logic [7:0] cnt);
        logic [31:0] s;
        s                   = 32'h0000_0000;
        s[ST_EMPTY]         = empty;
        s[ST_FULL]          = full;
        s[ST_OVF]           = ovf;
        s[ST_CNT_LSB +: 8]  = cnt;
        return s;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: core data port plus TX byte stream.
//   memWrite/addr/writeData : M-stage store request (core -> responder)
//   readData                : load data, combinational (responder -> core)
//   tx_data/tx_valid        : FIFO head byte stream (responder -> consumer)
//   tx_ready                : consumer accepts head (consumer -> responder)
// The master modport is the environment side (core plus stream consumer).
interface data_mem_responder_if #(
    parameter int WIDTH = 32
);
    logic             memWrite;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] writeData;
    logic [WIDTH-1:0] readData;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;

    modport master (
        output memWrite, addr, writeData, tx_ready,
        input  readData, tx_data, tx_valid
    );

    modport slave (
        input  memWrite, addr, writeData, tx_ready,
        output readData, tx_data, tx_valid
    );
endinterface

// File: rtl/data_mem_responder_tx_fifo.sv
// tx_fifo: synchronous byte FIFO, DEPTH entries (power of 2, >= 2).
//   clk, reset  : clock, synchronous active-high reset (empties the FIFO)
//   push, din   : enqueue din; ignored when full unless a pop happens too
//   pop, dout   : dequeue head; dout is the current head entry
//   empty, full : occupancy flags
//   count       : number of stored entries, $clog2(DEPTH)+1 bits
module tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [7:0]             din,
    input  logic                   pop,
    output logic [7:0]             dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty = (count_r == (AW+1)'(0));
    assign full  = (count_r == (AW+1)'(DEPTH));
    assign count = count_r;
    assign dout  = mem_r[rd_ptr_r];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Storage array: payload only, never cleared.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-port responder with word RAM and MMIO block.
//   clk, reset : clock, synchronous active-high reset
//   bus        : data_mem_responder_if.slave (store request, load data,
//                TX byte stream)
//   gpio_out   : GPIO output register
// Build option DMEM_MMIO_EN: when defined, addresses with addr[31:16]==MMIO_HI
// reach the MMIO block (CYCLE, GPIO, TX_DATA, STATUS). When undefined every
// address maps to RAM and the GPIO/TX outputs are tied to zero.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          DEPTH_WORDS = 64,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] MMIO_HI     = MMIO_HI_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    data_mem_responder_if.slave bus,
    output logic [WIDTH-1:0]  gpio_out
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [WIDTH-1:0] ram_r [DEPTH_WORDS];
    logic [AW-1:0]    ram_idx_s;
    logic [WIDTH-1:0] ram_rdata_s;
    logic [WIDTH-1:0] rdata_s;
    logic             mmio_sel_s;
    logic             unused_s;

    // Upper address bits beyond the RAM index simply alias (wrap).
    assign ram_idx_s   = bus.addr[AW+1:2];
    assign ram_rdata_s = ram_r[ram_idx_s];
    assign unused_s    = ^{bus.addr, bus.tx_ready};

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.memWrite && !mmio_sel_s) begin
            ram_r[ram_idx_s] <= bus.writeData;
        end
    end

`ifdef DMEM_MMIO_EN
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       offset_s;
    logic [WIDTH-1:0] cycle_r;
    logic [WIDTH-1:0] gpio_r;
    logic             ovf_r;
    logic             push_s;
    logic             pop_s;
    logic             ovf_set_s;
    logic             ovf_clr_s;
    logic             empty_s;
    logic             full_s;
    logic [CW-1:0]    count_s;
    logic [7:0]       head_s;
    logic [WIDTH-1:0] status_s;

    assign mmio_sel_s = (bus.addr[WIDTH-1 -: 16] == MMIO_HI);
    assign offset_s   = bus.addr[7:0];

    assign push_s    = bus.memWrite && mmio_sel_s && (offset_s == OFF_TXDATA);
    assign pop_s     = bus.tx_valid && bus.tx_ready;
    // Only a push into a full FIFO with no simultaneous pop loses its byte.
    assign ovf_set_s = push_s && full_s && !pop_s;
    assign ovf_clr_s = bus.memWrite && mmio_sel_s && (offset_s == OFF_STATUS)
                       && bus.writeData[ST_OVF];

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .din   (bus.writeData[7:0]),
        .pop   (pop_s),
        .dout  (head_s),
        .empty (empty_s),
        .full  (full_s),
        .count (count_s)
    );

    assign status_s     = WIDTH'(status_word(empty_s, full_s, ovf_r, 8'(count_s)));
    assign bus.tx_valid = !empty_s;
    // Storage is not cleared, so mask the head while nothing is queued.
    assign bus.tx_data  = empty_s ? 8'h00 : head_s;
    assign gpio_out     = gpio_r;

    // MMIO state: cycle counter, GPIO register, sticky overflow (set beats clear).
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_r <= {WIDTH{1'b0}};
            gpio_r  <= {WIDTH{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            cycle_r <= cycle_r + WIDTH'(1);
            if (bus.memWrite && mmio_sel_s && (offset_s == OFF_GPIO)) begin
                gpio_r <= bus.writeData;
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Load data mux: MMIO register or RAM word.
    always_comb begin
        rdata_s = ram_rdata_s;
        if (mmio_sel_s) begin
            case (offset_s)
                OFF_CYCLE:  rdata_s = cycle_r;
                OFF_GPIO:   rdata_s = gpio_r;
                OFF_STATUS: rdata_s = status_s;
                default:    rdata_s = {WIDTH{1'b0}};
            endcase
        end else begin
            rdata_s = ram_rdata_s;
        end
    end
`else
    assign mmio_sel_s   = 1'b0;
    assign bus.tx_valid = 1'b0;
    assign bus.tx_data  = 8'h00;
    assign gpio_out     = {WIDTH{1'b0}};

    // Load data: RAM only.
    always_comb begin
        rdata_s = ram_rdata_s;
    end
`endif

    assign bus.readData = rdata_s;
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a reference model of RAM,
// MMIO registers and TX queue compared every cycle, plus hand-computed
// literal expectations. Works with DMEM_MMIO_EN defined or undefined.
module tb_data_mem_responder;

`ifdef DMEM_MMIO_EN
    localparam bit MMIO_ON = 1'b1;
`else
    localparam bit MMIO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] gpio_out;

    always #5 clk = ~clk;

    data_mem_responder_if #(.WIDTH(32)) bus ();

    data_mem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .gpio_out (gpio_out)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mem_m   [64];
    bit          known_m [64];
    bit   [31:0] cyc_m   = 32'd0;
    bit   [31:0] gpio_m  = 32'd0;
    bit          ovf_m   = 1'b0;
    logic [7:0]  q_m [$];
    bit          model_ok = 1'b0;

    function automatic bit is_mmio(input logic [31:0] a);
        return MMIO_ON && (a[31:16] == 16'hFFFF);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'h3F);
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = 32'd0;
        s[0]    = (q_m.size() == 0);
        s[1]    = (q_m.size() == 8);
        s[2]    = ovf_m;
        s[15:8] = 8'(q_m.size());
        return s;
    endfunction

    // Model state advance at each rising edge from the inputs seen there.
    always @(posedge clk) begin
        int  n;
        bit  pop;
        bit  push;
        bit  wr_mmio;
        wr_mmio = bus.memWrite && is_mmio(bus.addr);
        if (bus.memWrite && !is_mmio(bus.addr)) begin
            mem_m[widx(bus.addr)]   = bus.writeData;
            known_m[widx(bus.addr)] = 1'b1;
        end
        if (reset) begin
            q_m.delete();
            cyc_m    = 32'd0;
            gpio_m   = 32'd0;
            ovf_m    = 1'b0;
            model_ok = 1'b1;
        end else if (MMIO_ON) begin
            n    = q_m.size();
            pop  = (n > 0) && bus.tx_ready;
            push = wr_mmio && (bus.addr[7:0] == 8'h08);
            cyc_m = cyc_m + 32'd1;
            if (pop) void'(q_m.pop_front());
            if (push) begin
                if (n == 8 && !pop) ovf_m = 1'b1;
                else                q_m.push_back(bus.writeData[7:0]);
            end
            if (wr_mmio && bus.addr[7:0] == 8'h0C && bus.writeData[2]) ovf_m = 1'b0;
            if (wr_mmio && bus.addr[7:0] == 8'h04) gpio_m = bus.writeData;
        end
    end

    // Continuous compare against the model, away from the active edge.
    always @(negedge clk) begin
        logic [31:0] exp_rd;
        bit          rd_known;
        if (model_ok && !reset) begin
            check("gpio_out", gpio_out, gpio_m);
            check("tx_valid", {31'd0, bus.tx_valid}, {31'd0, q_m.size() != 0});
            check("tx_data", {24'd0, bus.tx_data}, {24'd0, (q_m.size() != 0) ? q_m[0] : 8'h00});
            rd_known = 1'b1;
            if (is_mmio(bus.addr)) begin
                case (bus.addr[7:0])
                    8'h00:   exp_rd = cyc_m;
                    8'h04:   exp_rd = gpio_m;
                    8'h0C:   exp_rd = exp_status();
                    default: exp_rd = 32'd0;
                endcase
            end else begin
                exp_rd   = mem_m[widx(bus.addr)];
                rd_known = known_m[widx(bus.addr)];
            end
            if (rd_known) check("readData", bus.readData, exp_rd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit w, input logic [31:0] a, input logic [31:0] d);
        bus.memWrite  = w;
        bus.addr      = a;
        bus.writeData = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        bus.tx_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        step();
        reset = 1'b0;

        // RAM write, same-cycle read, address wrap
        drive(1'b1, 32'h10, 32'hDEADBEEF);
        step();
        drive(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        check("ram_read", bus.readData, 32'hDEADBEEF);
        drive(1'b0, 32'h10 + 32'd256, 32'h0);
        #1;
        check("ram_wrap", bus.readData, 32'hDEADBEEF);
        step();

        // Read-during-write returns old contents
        drive(1'b1, 32'h20, 32'd5);
        step();
        drive(1'b1, 32'h20, 32'd9);
        @(negedge clk);
        check("rdw_old", bus.readData, 32'd5);
        step();
        drive(1'b0, 32'h20, 32'h0);
        @(negedge clk);
        check("rdw_new", bus.readData, 32'd9);
        step();

`ifdef DMEM_MMIO_EN
        // Cycle counter counts edges since reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 32'hFFFF0000, 32'h0);
        repeat (10) step();
        @(negedge clk);
        check("cycle_10", bus.readData, 32'd10);
        step();

        // GPIO
        drive(1'b1, 32'hFFFF0004, 32'h55);
        step();
        drive(1'b0, 32'hFFFF0004, 32'h0);
        @(negedge clk);
        check("gpio_out_55", gpio_out, 32'h55);
        check("gpio_read_55", bus.readData, 32'h55);
        step();

        // TX stream: push A,B,C with consumer stalled
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hFFFF0008, 32'h41 + i);
            step();
        end
        drive(1'b0, 32'hFFFF000C, 32'h0);
        @(negedge clk);
        check("status_cnt3", bus.readData, 32'h0000_0300);
        check("head_A", {24'd0, bus.tx_data}, 32'h41);
        step();
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("drain_abc", {24'd0, bus.tx_data}, 32'h41 + i);
            step();
        end
        bus.tx_ready = 1'b0;
        @(negedge clk);
        check("drained_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("status_empty", bus.readData, 32'h0000_0001);
        step();

        // Overflow: 9 pushes into 8 entries
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 32'hFFFF0008, 32'h10 + i);
            step();
        end
        drive(1'b0, 32'hFFFF000C, 32'h0);
        @(negedge clk);
        check("status_full_ovf", bus.readData, 32'h0000_0806);
        step();

        // Push while full with a simultaneous pop: count stays 8
        bus.tx_ready = 1'b1;
        drive(1'b1, 32'hFFFF0008, 32'h20);
        step();
        bus.tx_ready = 1'b0;
        drive(1'b0, 32'hFFFF000C, 32'h0);
        @(negedge clk);
        check("status_full_pp", bus.readData, 32'h0000_0806);
        step();

        // W1C overflow
        drive(1'b1, 32'hFFFF000C, 32'h4);
        step();
        drive(1'b0, 32'hFFFF000C, 32'h0);
        @(negedge clk);
        check("status_w1c", bus.readData, 32'h0000_0802);
        step();

        // Drain all 8: 0x11..0x17 then 0x20 (0x18 was dropped)
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("drain_ovf", {24'd0, bus.tx_data}, (i < 7) ? (32'h11 + i) : 32'h20);
            step();
        end
        bus.tx_ready = 1'b0;

        // Refill 4 bytes, then reset with a pop in flight
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hFFFF0008, 32'h30 + i);
            step();
        end
        bus.tx_ready = 1'b1;
        drive(1'b0, 32'h10, 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.tx_ready = 1'b0;
        drive(1'b0, 32'hFFFF0000, 32'h0);
        @(negedge clk);
        check("rst_cycle", bus.readData, 32'd0);
        check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("rst_gpio", gpio_out, 32'd0);
        step();
`else
        // Without MMIO the window aliases into RAM
        drive(1'b1, 32'hFFFF0004, 32'h12345678);
        step();
        drive(1'b0, 32'hFFFF0004, 32'h0);
        @(negedge clk);
        check("nommio_read", bus.readData, 32'h12345678);
        check("nommio_gpio", gpio_out, 32'd0);
        drive(1'b0, 32'h4, 32'h0);
        #1;
        check("nommio_idx1", bus.readData, 32'h12345678);
        step();
        bus.tx_ready = 1'b1;
        drive(1'b1, 32'hFFFF0008, 32'h41);
        step();
        drive(1'b0, 32'h8, 32'h0);
        @(negedge clk);
        check("nommio_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("nommio_idx2", bus.readData, 32'h41);
        bus.tx_ready = 1'b0;
        step();
`endif

        // RAM contents survive reset
        reset = 1'b1;
        drive(1'b0, 32'h10, 32'h0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("ram_after_reset", bus.readData, 32'hDEADBEEF);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
